// File: rtl/ahb_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_arbiter
//
// Two-master AHB arbiter with a shared address-phase mux and a data-phase
// write-data mux.
//   Master 0 : data-memory wrapper (DM)
//   Master 1 : instruction-memory fetch wrapper (IM)
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   M0_* / M1_*                  per-master request, lock and address phase
//                                (HAddress/HTrans/HSize/HWrite) plus write data
//   M0_HGrant, M1_HGrant         grant, one-hot or zero, decoded from state
//   HReady, HResp                slave handshake; HResp 2'b01 is ERROR
//   HAddress, HTrans, HSize,
//   HWrite, HLock                shared address phase of the granted master
//                                (IDLE values when no master owns the bus)
//   HWrite_data                  write data of the data-phase owner
//   HMaster                      address-phase owner
//   HMaster_data                 data-phase owner (HMaster delayed one
//                                HReady=1 edge)
// ----------------------------------------------------------------------------
module ahb_arbiter #(
   parameter int AHB_TRANS_BITS = 2,
   parameter int AHB_SIZE_BITS  = 3,
   parameter int MAX_HOLD       = 8
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      M0_HReq,
   input  logic                      M0_HLock,
   input  logic [31:0]               M0_HAddress,
   input  logic [AHB_TRANS_BITS-1:0] M0_HTrans,
   input  logic [AHB_SIZE_BITS-1:0]  M0_HSize,
   input  logic                      M0_HWrite,
   input  logic [31:0]               M0_HWrite_data,
   output logic                      M0_HGrant,

   input  logic                      M1_HReq,
   input  logic                      M1_HLock,
   input  logic [31:0]               M1_HAddress,
   input  logic [AHB_TRANS_BITS-1:0] M1_HTrans,
   input  logic [AHB_SIZE_BITS-1:0]  M1_HSize,
   input  logic                      M1_HWrite,
   input  logic [31:0]               M1_HWrite_data,
   output logic                      M1_HGrant,

   input  logic                      HReady,
   input  logic [1:0]                HResp,

   output logic [31:0]               HAddress,
   output logic [AHB_TRANS_BITS-1:0] HTrans,
   output logic [AHB_SIZE_BITS-1:0]  HSize,
   output logic                      HWrite,
   output logic                      HLock,
   output logic [31:0]               HWrite_data,
   output logic                      HMaster,
   output logic                      HMaster_data
);

   localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      PARK = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // One master's address phase, bundled so the mux is a single select.
   typedef struct packed {
      logic [31:0]               addr;
      logic [AHB_TRANS_BITS-1:0] trans;
      logic [AHB_SIZE_BITS-1:0]  size;
      logic                      write;
      logic                      lock;
   } addr_phase_t;

   // Value driven while parked: IDLE transfer, word size, no lock.
   localparam addr_phase_t AP_IDLE = '{
      addr  : 32'h0,
      trans : '0,
      size  : AHB_SIZE_BITS'(2),
      write : 1'b0,
      lock  : 1'b0
   };

   state_t           state, state_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic             err_flag;
   logic             owner_locked;
   addr_phase_t      m0_ap, m1_ap, bus_ap;

   assign m0_ap = '{M0_HAddress, M0_HTrans, M0_HSize, M0_HWrite, M0_HLock};
   assign m1_ap = '{M1_HAddress, M1_HTrans, M1_HSize, M1_HWrite, M1_HLock};

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= PARK;
      else     state <= state_nxt;
   end

   // Current owner still asking for a locked sequence. PARK has no owner,
   // so a lock can never survive a parked cycle.
   always_comb begin
      owner_locked = 1'b0;
      case (state)
         OWN0:    owner_locked = M0_HReq & M0_HLock;
         OWN1:    owner_locked = M1_HReq & M1_HLock;
         default: owner_locked = 1'b0;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: next state. Arbitration only happens on HReady=1 edges; otherwise
   // the current owner is kept so an extended transfer is not disturbed.
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      if (HReady) begin
         if (owner_locked && !err_flag)
            state_nxt = state;
         // Starvation guard: M0 has kept the bus for MAX_HOLD edges while
         // M1 was waiting and M0 is not locking.
         else if (state == OWN0 && M1_HReq && !M0_HLock && hold_cnt == HOLD_LAST)
            state_nxt = OWN1;
         else if (M0_HReq)
            state_nxt = OWN0;
         else if (M1_HReq)
            state_nxt = OWN1;
         else
            state_nxt = PARK;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: outputs. Grants and mux select come straight from the state
   // register, so they follow the arbitration edge by one cycle and drop
   // immediately on reset.
   // -------------------------------------------------------------------------
   always_comb begin
      M0_HGrant = 1'b0;
      M1_HGrant = 1'b0;
      bus_ap    = AP_IDLE;
      case (state)
         OWN0: begin
            M0_HGrant = 1'b1;
            bus_ap    = m0_ap;
         end
         OWN1: begin
            M1_HGrant = 1'b1;
            bus_ap    = m1_ap;
         end
         // Masters drive NONSEQ even without a grant, so the parked bus must
         // be forced to IDLE rather than left on either master.
         default: bus_ap = AP_IDLE;
      endcase
   end

   assign HAddress = bus_ap.addr;
   assign HTrans   = bus_ap.trans;
   assign HSize    = bus_ap.size;
   assign HWrite   = bus_ap.write;
   assign HLock    = bus_ap.lock;

   // -------------------------------------------------------------------------
   // Consecutive M0 keeps while M1 waits. Only meaningful in OWN0; any
   // ownership change or M1 withdrawing restarts the count.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (HReady) begin
         if (state_nxt != state || !M1_HReq || state != OWN0)
            hold_cnt <= '0;
         else if (hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + 1'b1;
      end
   end

   // An ERROR response breaks a lock at the following arbitration only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         err_flag <= 1'b0;
      else if (HReady) err_flag <= (HResp == RESP_ERROR);
   end

   // -------------------------------------------------------------------------
   // Address/data-phase owners. HMaster keeps its last value while parked;
   // HMaster_data trails it by one completed transfer.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         HMaster      <= 1'b0;
         HMaster_data <= 1'b0;
      end else if (HReady) begin
         HMaster_data <= HMaster;
         case (state_nxt)
            OWN0:    HMaster <= 1'b0;
            OWN1:    HMaster <= 1'b1;
            default: HMaster <= HMaster;
         endcase
      end
   end

   // Write data belongs to the data phase, hence HMaster_data as select.
   always_comb begin
      if (rst)               HWrite_data = 32'h0;
      else if (HMaster_data) HWrite_data = M1_HWrite_data;
      else                   HWrite_data = M0_HWrite_data;
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;

   localparam int MAX_HOLD = 8;
   localparam logic [31:0] A0 = 32'h0000_1000;
   localparam logic [31:0] A1 = 32'h0000_0040;
   localparam logic [31:0] D0 = 32'hD0D0_0000;
   localparam logic [31:0] D1 = 32'hD1D1_1111;

   logic        clk = 1'b0;
   logic        rst;
   logic        M0_HReq, M0_HLock, M0_HWrite, M0_HGrant;
   logic        M1_HReq, M1_HLock, M1_HWrite, M1_HGrant;
   logic [31:0] M0_HAddress, M1_HAddress, M0_HWrite_data, M1_HWrite_data;
   logic [1:0]  M0_HTrans, M1_HTrans;
   logic [2:0]  M0_HSize, M1_HSize;
   logic        HReady;
   logic [1:0]  HResp;
   logic [31:0] HAddress, HWrite_data;
   logic [1:0]  HTrans;
   logic [2:0]  HSize;
   logic        HWrite, HLock, HMaster, HMaster_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ahb_arbiter #(.AHB_TRANS_BITS(2), .AHB_SIZE_BITS(3), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst),
      .M0_HReq(M0_HReq), .M0_HLock(M0_HLock), .M0_HAddress(M0_HAddress),
      .M0_HTrans(M0_HTrans), .M0_HSize(M0_HSize), .M0_HWrite(M0_HWrite),
      .M0_HWrite_data(M0_HWrite_data), .M0_HGrant(M0_HGrant),
      .M1_HReq(M1_HReq), .M1_HLock(M1_HLock), .M1_HAddress(M1_HAddress),
      .M1_HTrans(M1_HTrans), .M1_HSize(M1_HSize), .M1_HWrite(M1_HWrite),
      .M1_HWrite_data(M1_HWrite_data), .M1_HGrant(M1_HGrant),
      .HReady(HReady), .HResp(HResp),
      .HAddress(HAddress), .HTrans(HTrans), .HSize(HSize), .HWrite(HWrite),
      .HLock(HLock), .HWrite_data(HWrite_data),
      .HMaster(HMaster), .HMaster_data(HMaster_data)
   );

   // {g0,g1,hm,hmd,addr,trans,size,write,lock,wdata}
   function automatic logic [74:0] observed();
      return {M0_HGrant, M1_HGrant, HMaster, HMaster_data, HAddress, HTrans,
              HSize, HWrite, HLock, HWrite_data};
   endfunction

   function automatic logic [74:0] expect_vec(input int own, input logic hm,
                                              input logic hmd);
      logic [31:0] a;
      logic [1:0]  t;
      logic [2:0]  s;
      logic        w, l;
      a = 32'h0; t = 2'b00; s = 3'b010; w = 1'b0; l = 1'b0;
      if (own == 0) begin
         a = M0_HAddress; t = M0_HTrans; s = M0_HSize; w = M0_HWrite; l = M0_HLock;
      end else if (own == 1) begin
         a = M1_HAddress; t = M1_HTrans; s = M1_HSize; w = M1_HWrite; l = M1_HLock;
      end
      return {own == 0, own == 1, hm, hmd, a, t, s, w, l,
              hmd ? M1_HWrite_data : M0_HWrite_data};
   endfunction

   task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got g0g1=%b%b hm=%b hmd=%b addr=%h tr=%b sz=%b wr=%b lk=%b wd=%h | need g0g1=%b%b hm=%b hmd=%b addr=%h tr=%b sz=%b wr=%b lk=%b wd=%h",
                  name, act[74], act[73], act[72], act[71], act[70:39], act[38:37],
                  act[36:34], act[33], act[32], act[31:0],
                  exp[74], exp[73], exp[72], exp[71], exp[70:39], exp[38:37],
                  exp[36:34], exp[33], exp[32], exp[31:0]);
      end
   endtask

   // Directed vector: inputs for one cycle, expected state after the edge.
   typedef struct {
      logic       r0, l0, r1, l1, rdy;
      logic [1:0] resp;
      logic       g0, g1, hm, hmd;
   } vec_t;

   vec_t tbl[$];

   // bits: r0 l0 r1 l1 rdy resp[1:0] | g0 g1 hm hmd
   task automatic add(input logic [10:0] b, input int n);
      vec_t v;
      v = '{b[10], b[9], b[8], b[7], b[6], b[5:4], b[3], b[2], b[1], b[0]};
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   // Reference model state
   int   m_own, m_cnt;
   logic m_err, m_hm, m_hmd;

   task automatic model_reset();
      m_own = -1; m_cnt = 0; m_err = 1'b0; m_hm = 1'b0; m_hmd = 1'b0;
   endtask

   task automatic model_edge();
      logic req[2];
      logic lck[2];
      int   nxt;
      req[0] = M0_HReq; req[1] = M1_HReq;
      lck[0] = M0_HLock; lck[1] = M1_HLock;
      if (!HReady) return;
      if (m_own >= 0 && req[m_own] && lck[m_own] && !m_err)        nxt = m_own;
      else if (m_own == 0 && req[1] && !lck[0] && m_cnt == MAX_HOLD - 1) nxt = 1;
      else if (req[0])                                             nxt = 0;
      else if (req[1])                                             nxt = 1;
      else                                                         nxt = -1;
      if (nxt != m_own || !req[1] || m_own != 0) m_cnt = 0;
      else if (m_cnt < MAX_HOLD - 1)             m_cnt = m_cnt + 1;
      m_hmd = m_hm;
      if (nxt >= 0) m_hm = (nxt == 1);
      m_err = (HResp == 2'b01);
      m_own = nxt;
   endtask

   logic [74:0] idle_vec;

   initial begin
      idle_vec = {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 3'b010, 1'b0, 1'b0, 32'h0};

      rst = 1'b1;
      M0_HReq = 0; M0_HLock = 0; M1_HReq = 0; M1_HLock = 0;
      M0_HAddress = A0; M1_HAddress = A1;
      M0_HTrans = 2'b10; M1_HTrans = 2'b10;
      M0_HSize = 3'b010; M1_HSize = 3'b001;
      M0_HWrite = 1'b1; M1_HWrite = 1'b0;
      M0_HWrite_data = D0; M1_HWrite_data = D1;
      HReady = 1'b1; HResp = 2'b00;

      // ---------------- directed table ----------------
      add(11'b0_0_0_0_1_00_0_0_0_0, 5);  // idle after reset
      add(11'b0_0_1_0_1_00_0_1_1_0, 1);  // M1 alone
      add(11'b0_0_1_0_1_00_0_1_1_1, 1);
      add(11'b0_0_0_0_1_00_0_0_1_1, 1);
      add(11'b1_0_1_0_1_00_1_0_0_1, 1);  // simultaneous -> M0
      add(11'b0_0_1_0_1_00_0_1_1_0, 1);  // M0 drops -> M1
      add(11'b0_0_0_0_1_00_0_0_1_1, 1);
      add(11'b1_0_1_0_1_00_1_0_0_1, 1);  // starvation guard
      add(11'b1_0_1_0_1_00_1_0_0_0, 7);
      add(11'b1_0_1_0_1_00_0_1_1_0, 1);
      add(11'b1_0_0_0_1_00_1_0_0_1, 1);
      add(11'b0_0_0_0_1_00_0_0_0_0, 1);
      add(11'b0_0_1_0_1_00_0_1_1_0, 1);  // HReady stall in OWN1
      add(11'b0_0_1_0_1_00_0_1_1_1, 1);
      add(11'b1_0_1_0_0_00_0_1_1_1, 3);
      add(11'b1_0_1_0_1_00_1_0_0_1, 1);  // wdata still from M1
      add(11'b1_0_0_0_1_00_1_0_0_0, 1);
      add(11'b0_0_0_0_1_00_0_0_0_0, 1);
      add(11'b1_1_1_0_1_00_1_0_0_0, 2);  // M0 locked
      add(11'b1_1_1_0_1_01_1_0_0_0, 1);  // ERROR seen
      add(11'b1_1_1_0_1_00_1_0_0_0, 1);  // M0 wins by priority
      add(11'b0_0_1_1_1_00_0_1_1_0, 1);  // M1 locked
      add(11'b1_0_1_1_1_00_0_1_1_1, 1);  // lock holds vs M0
      add(11'b1_0_1_1_1_01_0_1_1_1, 1);  // ERROR seen
      add(11'b1_0_1_1_1_00_1_0_0_1, 1);  // lock broken -> M0
      add(11'b0_0_0_0_1_00_0_0_0_0, 1);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", observed(), idle_vec);
      rst = 1'b0;

      foreach (tbl[i]) begin
         int own;
         M0_HReq = tbl[i].r0; M0_HLock = tbl[i].l0;
         M1_HReq = tbl[i].r1; M1_HLock = tbl[i].l1;
         HReady = tbl[i].rdy; HResp = tbl[i].resp;
         @(posedge clk);
         #1;
         own = tbl[i].g0 ? 0 : (tbl[i].g1 ? 1 : -1);
         chk($sformatf("vec%0d", i), observed(), expect_vec(own, tbl[i].hm, tbl[i].hmd));
      end

      // ---------------- reset mid-OWN0 ----------------
      M0_HReq = 1'b1; M0_HLock = 1'b1; M1_HReq = 1'b1; M1_HLock = 1'b0;
      HReady = 1'b1; HResp = 2'b00;
      @(posedge clk);
      #1;
      chk("own0_before_reset", observed(), expect_vec(0, 1'b0, 1'b0));
      #2 rst = 1'b1;
      #1;
      chk("async_reset_mid_own0", observed(), idle_vec);
      @(posedge clk);
      #1;
      chk("reset_held_over_edge", observed(), idle_vec);
      rst = 1'b0;
      model_reset();

      // ---------------- randomized vs. model ----------------
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) M0_HReq  = ($urandom_range(3) != 0);
         if ($urandom_range(3) == 0) M1_HReq  = ($urandom_range(4) > 1);
         if ($urandom_range(5) == 0) M0_HLock = ($urandom_range(3) == 0);
         if ($urandom_range(5) == 0) M1_HLock = ($urandom_range(3) == 0);
         M0_HAddress    = $urandom;
         M1_HAddress    = $urandom;
         M0_HTrans      = 2'($urandom_range(3));
         M1_HTrans      = 2'($urandom_range(3));
         M0_HSize       = 3'($urandom_range(7));
         M1_HSize       = 3'($urandom_range(7));
         M0_HWrite      = 1'($urandom_range(1));
         M1_HWrite      = 1'($urandom_range(1));
         M0_HWrite_data = $urandom;
         M1_HWrite_data = $urandom;
         HReady         = ($urandom_range(6) != 0);
         if ($urandom_range(15) == 0)     HResp = 2'b01;
         else if ($urandom_range(9) == 0) HResp = 2'($urandom_range(3));
         else                             HResp = 2'b00;
         @(posedge clk);
         model_edge();
         #1;
         chk($sformatf("rand%0d", c), observed(), expect_vec(m_own, m_hm, m_hmd));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
